// File: rtl/ultrasound_echo_emulator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ultrasound_echo_emulator_pkg
// Brief    : Shared state encodings, default timing constants and the jitter
//            LFSR step function used by the echo emulator and its calculator.
// Revision : 1.0 - initial release
// ============================================================================
package ultrasound_echo_emulator_pkg;

    // FSM encoding; 5..7 are illegal and recover to IDLE
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_TRIG_HIGH = 3'd1,
        ST_BURST     = 3'd2,
        ST_ECHO      = 3'd3,
        ST_HOLDOFF   = 3'd4
    } state_t;

    // Default timing at 27 MHz
    localparam int c_trig_min        = 270;      // 10 us trigger
    localparam int c_burst_cycles    = 5400;     // 200 us burst
    localparam int c_holdoff_cycles  = 2700;
    localparam int c_cycles_per_inch = 3996;
    localparam int c_no_object       = 1026000;  // 38 ms

    localparam int         c_cnt_w     = 20;
    localparam logic [7:0] c_lfsr_seed = 8'hA5;

    // One step of the x^8+x^6+x^5+x^4+1 Fibonacci LFSR (shift left)
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ultrasound_echo_emulator_if.sv
`default_nettype none
// ============================================================================
// Module   : ultrasound_echo_emulator_if
// Brief    : Trigger/distance request and echo/status response bundle between
//            the location calculator (master) and the emulator (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface ultrasound_echo_emulator_if;
    logic       trigger;
    logic [7:0] distance;
    logic       echo;
    logic       busy;
    logic [2:0] state;

    modport master (
        output trigger,
        output distance,
        input  echo,
        input  busy,
        input  state
    );

    modport slave (
        input  trigger,
        input  distance,
        output echo,
        output busy,
        output state
    );
endinterface
`default_nettype wire

// File: rtl/ultrasound_echo_emulator_synchronize.sv
`default_nettype none
// ============================================================================
// Module   : synchronize
// Brief    : Two-flop single-bit synchronizer for an asynchronous input.
// Revision : 1.0 - initial release
// ============================================================================
module synchronize (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_async,
    output logic      o_sync
);
    logic r_meta;
    logic r_sync;

    // Two-stage capture; both stages clear on reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;
endmodule
`default_nettype wire

// File: rtl/ultrasound_echo_emulator.sv
`default_nettype none
// ============================================================================
// Module   : ultrasound_echo_emulator
// Brief    : Emulates an ultrasonic ranger. A qualified trigger pulse is
//            followed by a fixed burst delay, then an echo pulse whose width
//            encodes the distance latched at trigger fall, then a holdoff.
//            Optional macro ULTRASOUND_ECHO_JITTER_EN adds 0..255 cycles of
//            LFSR jitter to each echo width.
// Revision : 1.0 - initial release
// ============================================================================
module ultrasound_echo_emulator
    import ultrasound_echo_emulator_pkg::*;
#(
    parameter int TRIG_MIN         = c_trig_min,
    parameter int BURST_CYCLES     = c_burst_cycles,
    parameter int HOLDOFF_CYCLES   = c_holdoff_cycles,
    parameter int CYCLES_PER_INCH  = c_cycles_per_inch,
    parameter int NO_OBJECT_CYCLES = c_no_object
) (
    input  wire logic                  clock,
    input  wire logic                  reset,
    ultrasound_echo_emulator_if.slave  bus
);
    localparam logic [c_cnt_w-1:0] c_trig_min_w  = c_cnt_w'(TRIG_MIN);
    localparam logic [c_cnt_w-1:0] c_burst_last  = c_cnt_w'(BURST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last   = c_cnt_w'(HOLDOFF_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cpi         = c_cnt_w'(CYCLES_PER_INCH);
    localparam logic [c_cnt_w-1:0] c_no_obj      = c_cnt_w'(NO_OBJECT_CYCLES);

    state_t               r_state;
    state_t               w_state_next;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_cnt_w-1:0]   w_count_next;
    logic                 w_latch;
    logic [7:0]           r_dist;
    logic [c_cnt_w-1:0]   r_width;
    logic [c_cnt_w-1:0]   w_width_base;
    logic [c_cnt_w-1:0]   w_width_calc;
    logic                 r_echo;
    logic                 r_busy;
    logic                 w_trig_s;

    synchronize u_trig_sync (
        .clock   (clock),
        .reset   (reset),
        .i_async (bus.trigger),
        .o_sync  (w_trig_s)
    );

    // Echo width from the latched distance; zero means no object
    assign w_width_base = (r_dist == 8'd0) ? c_no_obj : ({12'd0, r_dist} * c_cpi);

`ifdef ULTRASOUND_ECHO_JITTER_EN
    logic [7:0] r_lfsr;

    // Jitter source advances once per qualified trigger
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lfsr <= c_lfsr_seed;
        end else if (w_latch) begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    assign w_width_calc = w_width_base + {12'd0, r_lfsr};
`else
    assign w_width_calc = w_width_base;
`endif

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and counter decisions, driven only by the synchronized trigger
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_latch      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trig_s) begin
                    w_state_next = ST_TRIG_HIGH;
                    w_count_next = c_cnt_w'(1);
                end
            end
            ST_TRIG_HIGH: begin
                if (w_trig_s) begin
                    if (r_count < c_trig_min_w) begin
                        w_count_next = r_count + c_cnt_w'(1);
                    end
                end else if (r_count >= c_trig_min_w) begin
                    w_state_next = ST_BURST;
                    w_count_next = '0;
                    w_latch      = 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                    w_count_next = '0;
                end
            end
            ST_BURST: begin
                if (r_count >= c_burst_last) begin
                    w_state_next = ST_ECHO;
                    w_count_next = '0;
                end else begin
                    w_count_next = r_count + c_cnt_w'(1);
                end
            end
            ST_ECHO: begin
                if (r_count >= (r_width - c_cnt_w'(1))) begin
                    w_state_next = ST_HOLDOFF;
                    w_count_next = '0;
                end else begin
                    w_count_next = r_count + c_cnt_w'(1);
                end
            end
            ST_HOLDOFF: begin
                // Count saturates; leaving waits for the trigger to be released
                if (r_count >= c_hold_last) begin
                    if (!w_trig_s) begin
                        w_state_next = ST_IDLE;
                        w_count_next = '0;
                    end
                end else begin
                    w_count_next = r_count + c_cnt_w'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_count_next = '0;
            end
        endcase
    end

    // Datapath: counter, distance latch, width capture and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_dist  <= 8'd0;
            r_width <= '0;
            r_echo  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_echo  <= (w_state_next == ST_ECHO);
            r_busy  <= (w_state_next != ST_IDLE);
            if (w_latch) begin
                r_dist <= bus.distance;
            end
            if ((r_state == ST_BURST) && (r_count == '0)) begin
                r_width <= w_width_calc;
            end
        end
    end

    assign bus.echo  = r_echo;
    assign bus.busy  = r_busy;
    assign bus.state = r_state;
endmodule
`default_nettype wire

// File: tb/tb_ultrasound_echo_emulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_ultrasound_echo_emulator
// Brief    : Directed self-checking bench for the echo emulator, using scaled
//            timing parameters so every scenario fits in a short run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ultrasound_echo_emulator;
    localparam int TB_TRIG_MIN = 8;
    localparam int TB_BURST    = 20;
    localparam int TB_HOLD     = 10;
    localparam int TB_CPI      = 4;
    localparam int TB_NO_OBJ   = 1500;
    // 2 synchronizer edges + 1 decision edge + burst length
    localparam int EXP_RISE    = TB_BURST + 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] jit_lfsr = 8'hA5;

    ultrasound_echo_emulator_if bus();

    ultrasound_echo_emulator #(
        .TRIG_MIN         (TB_TRIG_MIN),
        .BURST_CYCLES     (TB_BURST),
        .HOLDOFF_CYCLES   (TB_HOLD),
        .CYCLES_PER_INCH  (TB_CPI),
        .NO_OBJECT_CYCLES (TB_NO_OBJ)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse(input int n);
        bus.trigger = 1'b1;
        repeat (n) tick();
        bus.trigger = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        jit_lfsr = 8'hA5;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    // Jitter expected for the next qualified trigger (0 when jitter is off)
    function automatic int next_jitter();
`ifdef ULTRASOUND_ECHO_JITTER_EN
        jit_lfsr = {jit_lfsr[6:0], jit_lfsr[7] ^ jit_lfsr[5] ^ jit_lfsr[4] ^ jit_lfsr[3]};
        return int'(jit_lfsr);
`else
        return 0;
`endif
    endfunction

    // Cycles until echo rises (-1 on timeout), then its high width
    task automatic measure_echo(input int budget, output int rise, output int width);
        rise  = -1;
        width = 0;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (bus.echo === 1'b1) begin
                rise = k;
                break;
            end
        end
        if (rise >= 0) begin
            width = 1;
            for (int k = 0; k < 4000; k++) begin
                tick();
                if (bus.echo !== 1'b1) break;
                width++;
            end
        end
    endtask

    // Cycles until busy drops (-1 on timeout)
    task automatic wait_idle(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            tick();
            if (bus.busy === 1'b0) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.trigger  = 1'b0;
        bus.distance = 8'd0;
        reset = 1'b1;
        repeat (2) tick();
        checks++; if (bus.echo !== 1'b0) begin failures++; $display("FAIL reset_echo: got %b expected 0", bus.echo); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.state !== 3'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
        reset = 1'b0;
        repeat (5) tick();
        checks++; if (bus.state !== 3'd0) begin failures++; $display("FAIL post_reset_state: got %0d expected 0", bus.state); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_basic();
        int rise, width, n, j;
        bus.distance = 8'd10;
        pulse(10);
        j = next_jitter();
        measure_echo(200, rise, width);
        checks++; if (rise !== EXP_RISE) begin failures++; $display("FAIL basic_rise: got %0d expected %0d", rise, EXP_RISE); end
        checks++; if (width !== 40 + j) begin failures++; $display("FAIL basic_width: got %0d expected %0d", width, 40 + j); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy_holdoff: got %b expected 1", bus.busy); end
        wait_idle(100, n);
        checks++; if (n !== TB_HOLD) begin failures++; $display("FAIL basic_holdoff_len: got %0d expected %0d", n, TB_HOLD); end
        checks++; if (bus.state !== 3'd0) begin failures++; $display("FAIL basic_idle_state: got %0d expected 0", bus.state); end
    endtask

    task automatic test_short_trigger();
        int rise, width;
        bus.distance = 8'd10;
        pulse(TB_TRIG_MIN - 1);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL short_busy_during: got %b expected 1", bus.busy); end
        measure_echo(100, rise, width);
        checks++; if (rise !== -1) begin failures++; $display("FAIL short_no_echo: got rise %0d expected -1", rise); end
        checks++; if (bus.state !== 3'd0) begin failures++; $display("FAIL short_state: got %0d expected 0", bus.state); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL short_busy_after: got %b expected 0", bus.busy); end
    endtask

    task automatic test_min_trigger();
        int rise, width, n, j;
        bus.distance = 8'd1;
        pulse(TB_TRIG_MIN);
        j = next_jitter();
        measure_echo(200, rise, width);
        checks++; if (rise !== EXP_RISE) begin failures++; $display("FAIL min_rise: got %0d expected %0d", rise, EXP_RISE); end
        checks++; if (width !== 4 + j) begin failures++; $display("FAIL min_width: got %0d expected %0d", width, 4 + j); end
        wait_idle(100, n);
        checks++; if (n !== TB_HOLD) begin failures++; $display("FAIL min_holdoff_len: got %0d expected %0d", n, TB_HOLD); end
    endtask

    task automatic test_distance();
        int rise, width, n, j;
        // No object
        bus.distance = 8'd0;
        pulse(10);
        j = next_jitter();
        measure_echo(200, rise, width);
        checks++; if (width !== TB_NO_OBJ + j) begin failures++; $display("FAIL dist0_width: got %0d expected %0d", width, TB_NO_OBJ + j); end
        wait_idle(100, n);
        // Maximum distance
        bus.distance = 8'd255;
        pulse(10);
        j = next_jitter();
        measure_echo(200, rise, width);
        checks++; if (width !== 1020 + j) begin failures++; $display("FAIL dist255_width: got %0d expected %0d", width, 1020 + j); end
        wait_idle(100, n);
        // Distance changed mid-echo must not alter the width
        bus.distance = 8'd10;
        pulse(10);
        j = next_jitter();
        rise = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (bus.echo === 1'b1) begin
                rise = k;
                break;
            end
        end
        bus.distance = 8'd3;
        width = (rise >= 0) ? 1 : 0;
        for (int k = 0; k < 4000 && rise >= 0; k++) begin
            tick();
            if (bus.echo !== 1'b1) break;
            width++;
        end
        checks++; if (width !== 40 + j) begin failures++; $display("FAIL dist_change_width: got %0d expected %0d", width, 40 + j); end
        wait_idle(100, n);
        // Back-to-back transaction right after idle
        bus.distance = 8'd2;
        pulse(10);
        j = next_jitter();
        measure_echo(200, rise, width);
        checks++; if (rise !== EXP_RISE) begin failures++; $display("FAIL b2b_rise: got %0d expected %0d", rise, EXP_RISE); end
        checks++; if (width !== 8 + j) begin failures++; $display("FAIL b2b_width: got %0d expected %0d", width, 8 + j); end
        wait_idle(100, n);
    endtask

    task automatic test_reset_mid_echo();
        int rise, echoes;
        bus.distance = 8'd200;
        pulse(10);
        rise = -1;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (bus.echo === 1'b1) begin
                rise = k;
                break;
            end
        end
        checks++; if (rise !== EXP_RISE) begin failures++; $display("FAIL midreset_rise: got %0d expected %0d", rise, EXP_RISE); end
        repeat (15) tick();
        reset = 1'b1;
        jit_lfsr = 8'hA5;
        #1;
        checks++; if (bus.echo !== 1'b0) begin failures++; $display("FAIL midreset_echo: got %b expected 0", bus.echo); end
        checks++; if (bus.state !== 3'd0) begin failures++; $display("FAIL midreset_state: got %0d expected 0", bus.state); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
        repeat (3) tick();
        reset = 1'b0;
        echoes = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (bus.echo !== 1'b0) echoes++;
        end
        checks++; if (echoes !== 0) begin failures++; $display("FAIL midreset_residual: got %0d echo cycles expected 0", echoes); end
    endtask

    task automatic test_trigger_at_release();
        int rise, width, n, j;
        bus.distance = 8'd5;
        reset = 1'b1;
        jit_lfsr = 8'hA5;
        bus.trigger = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
        bus.trigger = 1'b0;
        j = next_jitter();
        measure_echo(200, rise, width);
        checks++; if (rise !== EXP_RISE) begin failures++; $display("FAIL release_rise: got %0d expected %0d", rise, EXP_RISE); end
        checks++; if (width !== 20 + j) begin failures++; $display("FAIL release_width: got %0d expected %0d", width, 20 + j); end
        wait_idle(100, n);
    endtask

    task automatic test_held_trigger();
        int rise, width, n, j, echoes;
        bus.distance = 8'd3;
        pulse(10);
        j = next_jitter();
        repeat (3) tick();
        bus.trigger = 1'b1;  // raised during BURST and held
        measure_echo(200, rise, width);
        checks++; if (rise + 3 !== EXP_RISE) begin failures++; $display("FAIL held_rise: got %0d expected %0d", rise + 3, EXP_RISE); end
        checks++; if (width !== 12 + j) begin failures++; $display("FAIL held_width: got %0d expected %0d", width, 12 + j); end
        echoes = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (bus.echo !== 1'b0) echoes++;
        end
        checks++; if (echoes !== 0) begin failures++; $display("FAIL held_extra_echo: got %0d echo cycles expected 0", echoes); end
        checks++; if (bus.state !== 3'd4) begin failures++; $display("FAIL held_state: got %0d expected 4", bus.state); end
        bus.trigger = 1'b0;
        wait_idle(50, n);
        checks++; if (n !== 3) begin failures++; $display("FAIL held_release_idle: got %0d expected 3", n); end
        echoes = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.echo !== 1'b0) echoes++;
        end
        checks++; if (echoes !== 0) begin failures++; $display("FAIL held_after_release: got %0d echo cycles expected 0", echoes); end
        pulse(10);
        j = next_jitter();
        measure_echo(200, rise, width);
        checks++; if (rise !== EXP_RISE) begin failures++; $display("FAIL held_second_rise: got %0d expected %0d", rise, EXP_RISE); end
        checks++; if (width !== 12 + j) begin failures++; $display("FAIL held_second_width: got %0d expected %0d", width, 12 + j); end
        wait_idle(100, n);
    endtask

    initial begin
        bus.trigger  = 1'b0;
        bus.distance = 8'd0;
        test_reset();
        jit_lfsr = 8'hA5;
        test_basic();
        test_short_trigger();
        test_min_trigger();
        test_distance();
        test_reset_mid_echo();
        test_trigger_at_release();
        test_held_trigger();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always terminates
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
